rep_string_sequencer: RTL and testbench
=======================================

Name: rep_string_sequencer

Overview:
Sequences REP/REPE/REPNE-prefixed string instructions (MOVS, STOS, LODS, CMPS, SCAS) into per-iteration micro-ops for the execute stage.
- Sits between register-read and execute_top.
- Tracks ECX, ESI and EDI, and applies the DF-directed stride.
- For compare-type ops, waits on ZF feedback from execute to decide early termination.
- Non-REP string ops pass through as a single micro-op.

Parameters:
- AW, 32, width of ECX/ESI/EDI counters and address outputs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; synchronous abort of any sequence in progress
- in_valid  in  1  instruction available from register-read
- in_ready  out  1  sequencer can accept an instruction
- in_rep_mode  in  2  00 no prefix, 01 REP/REPE, 10 REPNE, 11 treated as 01
- in_is_cmp  in  1  op is CMPS/SCAS (ZF-terminated)
- in_opsize  in  2  0 = byte, 1 = word, 2 = dword, 3 treated as dword
- in_df  in  1  direction flag; 1 = decrement
- in_ecx  in  AW  initial count
- in_esi  in  AW  initial source pointer
- in_edi  in  AW  initial destination pointer
- uop_valid  out  1  micro-op valid toward execute
- uop_ready  in  1  execute accepts micro-op
- uop_esi  out  AW  source address for this iteration
- uop_edi  out  AW  destination address for this iteration
- uop_ecx  out  AW  ECX value after this iteration
- uop_last  out  1  final iteration by count (uop_ecx == 0, or non-REP)
- uop_skip  out  1  REP with ECX = 0: architectural no-op, retire only
- zf_valid  in  1  execute reports compare result for the last accepted CMP micro-op
- zf  in  1  zero flag from that compare
- done  out  1  one-cycle pulse: sequence finished
- done_ecx  out  AW  final ECX, valid with done
- done_esi  out  AW  final ESI, valid with done
- done_edi  out  AW  final EDI, valid with done
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT_ZF, FIN.
- Reset or flush (flush has priority over every other event):
  - state <= IDLE; all registered outputs are 0.
  - in_ready = 1 in IDLE; uop_valid, done and busy are 0.
  - No done pulse is produced on flush.
- IDLE:
  - in_ready = 1 only in IDLE.
  - On in_valid, latch all in_* fields and go to ISSUE. The first uop_valid appears the next cycle (1-cycle latency).
- stride = 1/2/4 per opsize, negated when df = 1. All pointer arithmetic is modulo 2^AW.
- ISSUE, uop_valid = 1:
  - uop_esi/uop_edi are the current pointers.
  - uop_ecx = ecx - 1 for REP, or ecx unchanged for non-REP.
  - Outputs stay stable until uop_ready (no drop or change while stalled).
- Non-REP: one micro-op with uop_last = 1. On handshake, pointers += stride, then go to FIN.
- REP with latched ecx = 0: one micro-op with uop_skip = 1, uop_last = 1, pointers unchanged. On handshake, go to FIN.
- REP with ecx > 0, on handshake:
  - ecx <= ecx - 1; esi/edi += stride.
  - If in_is_cmp, go to WAIT_ZF.
  - Otherwise, go to FIN if the new ecx = 0, else stay in ISSUE.
  - Back-to-back handshakes give 1 micro-op per cycle.
- WAIT_ZF: uop_valid = 0. zf_valid is ignored in every other state. On zf_valid:
  - Terminate if (REPE and zf = 0), (REPNE and zf = 1), or ecx = 0; go to FIN.
  - Otherwise return to ISSUE.
- FIN:
  - done = 1 for exactly one cycle, with done_* = latched ecx/esi/edi.
  - Next state IDLE; in_ready = 1 the following cycle.
- ECX = 0xFFFFFFFF is legal; the count is fully 32-bit, with no overflow special case.
- A flush in the same cycle as a uop handshake wins: the state is discarded.

Decomposition:
- Shared package (rep_seq_pkg):
  - REP mode encodings (REP_NONE, REP_E, REP_NE).
  - State encodings (ST_IDLE, ST_ISSUE, ST_WAIT_ZF, ST_FIN).
  - Opsize-to-stride constants.
- One natural sub-module: rep_stride_adder. It computes ±1/2/4 pointer update for ESI and EDI from opsize and df. Instantiate it twice.

Test Plan:
1. REP MOVSB: ecx = 3, esi = 0x100, edi = 0x200, df = 0, uop_ready = 1 → 3 uops.
   - esi = 0x100/0x101/0x102, uop_ecx = 2/1/0, uop_last on the third.
   - done with ecx = 0, esi = 0x103, edi = 0x203.
2. REP STOSD: df = 1, edi = 0x10, ecx = 2 → uop_edi = 0x10 then 0x0C; done_edi = 0x08.
   - Stall uop_ready low for 4 cycles mid-sequence → outputs held stable.
3. REPE CMPSW: ecx = 5, zf responses 1, 1, 0 → exactly 3 uops, each waiting for zf_valid; done_ecx = 2, done_esi = base + 6.
4. REP MOVSB with ecx = 0 → one uop with uop_skip = 1, uop_last = 1; done with pointers unchanged.
5. Non-REP LODSW: esi = 0xFFFFFFFF, df = 0 → single uop with uop_last = 1, uop_ecx = in_ecx; done_esi = 0x00000001 (wrap).
6. Flush asserted during second iteration of REP MOVSB (ecx = 4) → next cycle uop_valid = 0, busy = 0, in_ready = 1, no done pulse. Reset mid-sequence behaves identically.

Source files
------------

// File: rtl/rep_seq_pkg.sv
// rep_seq_pkg: shared encodings and stride constants for the REP string sequencer
package rep_seq_pkg;
  typedef enum logic [1:0] {REP_NONE = 2'd0, REP_E = 2'd1, REP_NE = 2'd2} rep_mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ZF, ST_FIN} state_t;
  localparam logic [2:0] STRIDE_B = 3'd1;
  localparam logic [2:0] STRIDE_W = 3'd2;
  localparam logic [2:0] STRIDE_D = 3'd4;
  function automatic logic [2:0] stride_of(logic [1:0] opsize);
    return opsize == 2'd0 ? STRIDE_B : opsize == 2'd1 ? STRIDE_W : STRIDE_D;
  endfunction
endpackage

// File: rtl/rep_stride_adder.sv
// rep_stride_adder: advances a string pointer by +/-1/2/4 bytes, modulo 2^AW
module rep_stride_adder
  import rep_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] ptr,
  input  logic [1:0]    opsize,
  input  logic          df,
  output logic [AW-1:0] next
);
  logic [AW-1:0] mag;
  assign mag  = AW'(stride_of(opsize));
  assign next = df ? ptr - mag : ptr + mag;
endmodule

// File: rtl/rep_string_sequencer.sv
// rep_string_sequencer: expands REP/REPE/REPNE string instructions into per-iteration micro-ops
module rep_string_sequencer
  import rep_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_rep_mode,
  input  logic          in_is_cmp,
  input  logic [1:0]    in_opsize,
  input  logic          in_df,
  input  logic [AW-1:0] in_ecx,
  input  logic [AW-1:0] in_esi,
  input  logic [AW-1:0] in_edi,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [AW-1:0] uop_esi,
  output logic [AW-1:0] uop_edi,
  output logic [AW-1:0] uop_ecx,
  output logic          uop_last,
  output logic          uop_skip,
  input  logic          zf_valid,
  input  logic          zf,
  output logic          done,
  output logic [AW-1:0] done_ecx,
  output logic [AW-1:0] done_esi,
  output logic [AW-1:0] done_edi,
  output logic          busy
);
  state_t        state;
  rep_mode_t     mode;
  logic          is_cmp, df, rep, skip, term;
  logic [1:0]    opsize;
  logic [AW-1:0] ecx, esi, edi, ecx_dec, esi_nx, edi_nx;

  rep_stride_adder #(.AW(AW)) u_esi_add (.ptr(esi), .opsize(opsize), .df(df), .next(esi_nx));
  rep_stride_adder #(.AW(AW)) u_edi_add (.ptr(edi), .opsize(opsize), .df(df), .next(edi_nx));

  assign rep       = mode != REP_NONE;
  assign skip      = rep && ecx == '0;
  assign ecx_dec   = ecx - 1'b1;
  // ecx has already been decremented by the compare iteration being resolved
  assign term      = (mode == REP_E && !zf) || (mode == REP_NE && zf) || ecx == '0;
  assign in_ready  = state == ST_IDLE;
  assign busy      = state != ST_IDLE;
  assign uop_valid = state == ST_ISSUE;
  assign done      = state == ST_FIN;
  assign uop_esi   = esi;
  assign uop_edi   = edi;
  assign uop_ecx   = (rep && !skip) ? ecx_dec : ecx;
  assign uop_skip  = skip;
  assign uop_last  = !rep || uop_ecx == '0;
  assign done_ecx  = ecx;
  assign done_esi  = esi;
  assign done_edi  = edi;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= ST_IDLE;
      mode   <= REP_NONE;
      is_cmp <= 1'b0;
      opsize <= 2'd0;
      df     <= 1'b0;
      ecx    <= '0;
      esi    <= '0;
      edi    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state  <= ST_ISSUE;
          mode   <= in_rep_mode == 2'b10 ? REP_NE : in_rep_mode == 2'b00 ? REP_NONE : REP_E;
          is_cmp <= in_is_cmp;
          opsize <= in_opsize;
          df     <= in_df;
          ecx    <= in_ecx;
          esi    <= in_esi;
          edi    <= in_edi;
        end
        ST_ISSUE: if (uop_ready) begin
          if (!skip) begin
            esi <= esi_nx;
            edi <= edi_nx;
          end
          if (rep && !skip) ecx <= ecx_dec;
          state <= (!rep || skip) ? ST_FIN : is_cmp ? ST_WAIT_ZF : ecx_dec == '0 ? ST_FIN : ST_ISSUE;
        end
        ST_WAIT_ZF: if (zf_valid) state <= term ? ST_FIN : ST_ISSUE;
        ST_FIN: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rep_string_sequencer.sv
// tb_rep_string_sequencer: directed checks of the REP string sequencer
module tb_rep_string_sequencer;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, in_ready;
  logic [1:0]  in_rep_mode = 0, in_opsize = 0;
  logic        in_is_cmp = 0, in_df = 0;
  logic [31:0] in_ecx = 0, in_esi = 0, in_edi = 0;
  logic        uop_valid, uop_ready = 1, uop_last, uop_skip, zf_valid = 0, zf = 0, done, busy;
  logic [31:0] uop_esi, uop_edi, uop_ecx, done_ecx, done_esi, done_edi;
  int          checks = 0, failures = 0;

  rep_string_sequencer #(.AW(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rep_mode(in_rep_mode), .in_is_cmp(in_is_cmp), .in_opsize(in_opsize), .in_df(in_df),
    .in_ecx(in_ecx), .in_esi(in_esi), .in_edi(in_edi), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_esi(uop_esi), .uop_edi(uop_edi), .uop_ecx(uop_ecx), .uop_last(uop_last), .uop_skip(uop_skip),
    .zf_valid(zf_valid), .zf(zf), .done(done), .done_ecx(done_ecx), .done_esi(done_esi),
    .done_edi(done_edi), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] mode, input logic cmp, input logic [1:0] os, input logic d,
                       input logic [31:0] c, input logic [31:0] s, input logic [31:0] e);
    chk("in_ready_idle", {31'd0, in_ready}, 1);
    in_rep_mode = mode; in_is_cmp = cmp; in_opsize = os; in_df = d;
    in_ecx = c; in_esi = s; in_edi = e; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic expect_uop(input string tag, input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] c, input logic last, input logic skip);
    for (int i = 0; i < 20 && !uop_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, uop_valid}, 1);
    chk({tag, "_esi"}, uop_esi, s);
    chk({tag, "_edi"}, uop_edi, e);
    if (!skip) chk({tag, "_ecx"}, uop_ecx, c);
    chk({tag, "_last"}, {31'd0, uop_last}, {31'd0, last});
    chk({tag, "_skip"}, {31'd0, uop_skip}, {31'd0, skip});
    @(negedge clk);
  endtask

  task automatic give_zf(input string tag, input logic z);
    chk({tag, "_wait_novalid"}, {31'd0, uop_valid}, 0);
    @(negedge clk);
    chk({tag, "_still_waiting"}, {31'd0, uop_valid}, 0);
    zf_valid = 1; zf = z;
    @(negedge clk);
    zf_valid = 0;
  endtask

  task automatic expect_done(input string tag, input logic [31:0] c, input logic [31:0] s, input logic [31:0] e);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_done_ecx"}, done_ecx, c);
    chk({tag, "_done_esi"}, done_esi, s);
    chk({tag, "_done_edi"}, done_edi, e);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_uop_valid", {31'd0, uop_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_done_ecx", done_ecx, 0);
    reset = 0;
    @(negedge clk);
    // REP MOVSB, 3 iterations
    start(2'b01, 0, 2'd0, 0, 3, 32'h100, 32'h200);
    chk("t1_busy", {31'd0, busy}, 1);
    expect_uop("t1u0", 32'h100, 32'h200, 2, 0, 0);
    expect_uop("t1u1", 32'h101, 32'h201, 1, 0, 0);
    expect_uop("t1u2", 32'h102, 32'h202, 0, 1, 0);
    expect_done("t1", 0, 32'h103, 32'h203);
    // REP STOSD, df=1, stalled on second uop
    start(2'b11, 0, 2'd2, 1, 2, 32'h50, 32'h10);
    expect_uop("t2u0", 32'h50, 32'h10, 1, 0, 0);
    uop_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall_valid", {31'd0, uop_valid}, 1);
      chk("t2_stall_edi", uop_edi, 32'h0C);
      chk("t2_stall_ecx", uop_ecx, 0);
      @(negedge clk);
    end
    uop_ready = 1;
    expect_uop("t2u1", 32'h4C, 32'h0C, 0, 1, 0);
    expect_done("t2", 0, 32'h48, 32'h08);
    // REPE CMPSW, terminates on third compare
    start(2'b01, 1, 2'd1, 0, 5, 32'h1000, 32'h2000);
    expect_uop("t3u0", 32'h1000, 32'h2000, 4, 0, 0);
    give_zf("t3z0", 1);
    expect_uop("t3u1", 32'h1002, 32'h2002, 3, 0, 0);
    give_zf("t3z1", 1);
    expect_uop("t3u2", 32'h1004, 32'h2004, 2, 0, 0);
    give_zf("t3z2", 0);
    expect_done("t3", 2, 32'h1006, 32'h2006);
    // REPNE SCASB, ends on zf=1
    start(2'b10, 1, 2'd0, 0, 4, 32'h700, 32'h800);
    expect_uop("t3bu0", 32'h700, 32'h800, 3, 0, 0);
    give_zf("t3bz0", 0);
    expect_uop("t3bu1", 32'h701, 32'h801, 2, 0, 0);
    give_zf("t3bz1", 1);
    expect_done("t3b", 2, 32'h702, 32'h802);
    // REP with ecx=0 is a skip uop
    start(2'b01, 0, 2'd0, 0, 0, 32'h300, 32'h400);
    expect_uop("t4u0", 32'h300, 32'h400, 0, 1, 1);
    expect_done("t4", 0, 32'h300, 32'h400);
    // Non-REP LODSW with source wrap
    start(2'b00, 0, 2'd1, 0, 7, 32'hFFFF_FFFF, 32'h500);
    expect_uop("t5u0", 32'hFFFF_FFFF, 32'h500, 7, 1, 0);
    expect_done("t5", 7, 32'h1, 32'h502);
    // Flush during second iteration
    start(2'b01, 0, 2'd0, 0, 4, 32'h600, 32'h900);
    expect_uop("t6u0", 32'h600, 32'h900, 3, 0, 0);
    chk("t6_second_valid", {31'd0, uop_valid}, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("t6_flush_valid", {31'd0, uop_valid}, 0);
    chk("t6_flush_busy", {31'd0, busy}, 0);
    chk("t6_flush_ready", {31'd0, in_ready}, 1);
    chk("t6_flush_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("t6_flush_nodone", {31'd0, done}, 0);
    // Reset mid-sequence
    start(2'b01, 0, 2'd0, 0, 4, 32'h600, 32'h900);
    expect_uop("t7u0", 32'h600, 32'h900, 3, 0, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t7_rst_valid", {31'd0, uop_valid}, 0);
    chk("t7_rst_busy", {31'd0, busy}, 0);
    chk("t7_rst_ready", {31'd0, in_ready}, 1);
    chk("t7_rst_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("t7_rst_nodone", {31'd0, done}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
